// File: rtl/fetch_pkg.sv
// Shared constants and buffer-entry type for the instruction fetch controller.
package fetch_pkg;

  localparam int PC_W_DEF  = 10;
  localparam int INS_W_DEF = 16;
  localparam int DEPTH_DEF = 2;

  typedef struct packed {
    logic [PC_W_DEF-1:0]  pc;
    logic [INS_W_DEF-1:0] ins;
  } fetch_entry_t;

  // Unprogrammed memory reads back as this word.
  localparam logic [INS_W_DEF-1:0] HALT_WORD = '0;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry prefetch buffer with push/pop/flush and an occupancy count.
// Entry type is a parameter so the owner can widen pc/ins fields.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = DEPTH_DEF,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 pushEntry,
  output entry_t                 headEntry,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushEntry;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign headEntry = mem[rdPtr];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: PC, push decision, redirect priority and
// optional halt-on-zero-word (build macro FETCH_HALT_ON_ZERO_EN).
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int INS_W = INS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [PC_W-1:0]  im_pc,
  input  logic [INS_W-1:0] im_ins,
  output logic [INS_W-1:0] ins_out,
  output logic [PC_W-1:0]  ins_pc,
  output logic             ins_valid,
  input  logic             ins_ready,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             halted
);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] ins;
  } entry_t;

  localparam int                CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     FULL = CW'(DEPTH);

  logic [PC_W-1:0] pc;
  logic [CW-1:0]   count;
  entry_t          head;
  entry_t          tail;
  logic            pop;
  logic            push;
  logic            room;
  logic            haltReg;
  logic            isHaltWord;

  // Handshake: the head transfers on a rising edge where ins_valid and
  // ins_ready are both 1; head data is held while ins_valid=1, ins_ready=0.
  assign ins_valid = (count != '0) && !redirect;
  assign pop       = ins_valid && ins_ready;
  assign room      = (count < FULL) || pop;
  assign push      = !haltReg && !redirect && room && !isHaltWord;

  assign tail.pc  = pc;
  assign tail.ins = im_ins;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pc <= '0;
    else if (redirect) pc <= redirect_pc;
    else if (push)     pc <= pc + 1'b1;
  end

`ifdef FETCH_HALT_ON_ZERO_EN
  assign isHaltWord = (im_ins == INS_W'(HALT_WORD));

  // The zero word halts fetch only at the point it would have been pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               haltReg <= 1'b0;
    else if (redirect)                        haltReg <= 1'b0;
    else if (!haltReg && room && isHaltWord)  haltReg <= 1'b1;
  end
`else
  assign isHaltWord = 1'b0;
  assign haltReg    = 1'b0;
`endif

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .pushEntry (tail),
    .headEntry (head),
    .count     (count)
  );

  assign im_pc   = pc;
  assign ins_out = head.ins;
  assign ins_pc  = head.pc;
  assign halted  = haltReg;

endmodule
